// File: rtl/base_sr_event_arb.sv
// -----------------------------------------------------------------------------
// base_sr_event_arb
//
// Purpose
//   Drains a vector of sticky set/reset event flags one event at a time, in
//   round-robin order. The block sits directly downstream of a per-bit sticky
//   latch: pend is the latch q, clr drives the latch rst.
//
//   For every pending bit the index is offered on a valid/ready port. Once the
//   consumer takes it, the block pulses that bit's clear for one cycle and then
//   returns to scanning. The latch updates at the end of the clear cycle, so
//   the next scan never sees the event that was just delivered (unless it was
//   set again in the meantime, which is a genuine new arrival).
//
// Parameters
//   width   number of event flags (>= 2, need not be a power of 2)
//   lwidth  index width, >= clog2(width)
//   cwidth  width of the delivered-event counter
//
// Ports
//   clk      in   1       clock, rising edge
//   reset_n  in   1       synchronous reset, active low
//   pend     in   width   sticky flags, bit i high = event i pending
//   clr      out  width   one-hot, one-cycle clear pulse to the latch rst
//   o_v      out  1       event index valid
//   o_r      in   1       consumer ready
//   o_idx    out  lwidth  index of the presented event
//   o_cnt    out  cwidth  count of accepted events, wraps
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module base_sr_event_arb #(
  parameter int width  = 8,
  parameter int lwidth = 3,
  parameter int cwidth = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [width-1:0]  pend,
  output logic [width-1:0]  clr,
  output logic              o_v,
  input  logic              o_r,
  output logic [lwidth-1:0] o_idx,
  output logic [cwidth-1:0] o_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [lwidth-1:0]   ptr_reg,   ptr_next;
  logic                v_reg,     v_next;
  logic [lwidth-1:0]   idx_reg,   idx_next;
  logic [width-1:0]    clr_reg,   clr_next;
  logic [cwidth-1:0]   cnt_reg,   cnt_next;

  // ---------------------------------------------------------------------------
  // Round-robin pick
  //
  // The search "first set bit at index >= ptr, wrapping" is split into two
  // plain priority encodes: the lowest set bit among the indices at or above
  // ptr wins; only if that region is empty does the lowest set bit overall
  // win (that is the wrapped part 0..ptr-1). This avoids a modulo on a
  // non-power-of-2 width.
  // ---------------------------------------------------------------------------
  logic [width-1:0]  upper_mask;
  logic [width-1:0]  pend_upper;
  logic              any_upper;
  logic [lwidth-1:0] pick_idx;
  logic [width-1:0]  idx_onehot;

  for (genvar gi = 0; gi < width; gi++) begin : g_mask
    assign upper_mask[gi] = (lwidth'(gi) >= ptr_reg);
  end

  // Decoded form of the presented index, used to build the clear pulse.
  for (genvar gi = 0; gi < width; gi++) begin : g_onehot
    assign idx_onehot[gi] = (idx_reg == lwidth'(gi));
  end

  // Lowest set bit of v; returns 0 for an all-zero vector (never used then).
  function automatic logic [lwidth-1:0] lowest_set(input logic [width-1:0] v);
    logic [lwidth-1:0] r;
    r = '0;
    for (int i = width - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = lwidth'(i);
      end
    end
    return r;
  endfunction

  assign pend_upper = pend & upper_mask;
  assign any_upper  = |pend_upper;
  assign pick_idx   = any_upper ? lowest_set(pend_upper) : lowest_set(pend);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      v_reg     <= 1'b0;
      idx_reg   <= '0;
      clr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      v_reg     <= v_next;
      idx_reg   <= idx_next;
      clr_reg   <= clr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  //
  // clr_next defaults to zero so the clear is a single-cycle pulse that can
  // only be raised on the PRESENT->CLEAR transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    v_next     = v_reg;
    idx_next   = idx_reg;
    clr_next   = '0;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (|pend) begin
          idx_next   = pick_idx;
          v_next     = 1'b1;
          state_next = PRESENT;
        end
      end

      PRESENT: begin
        // o_v and o_idx stay put until the handshake completes, even if the
        // flag behind them drops in the meantime.
        if (v_reg && o_r) begin
          v_next     = 1'b0;
          clr_next   = idx_onehot;
          cnt_next   = cnt_reg + cwidth'(1);
          // Restart the next scan just past the delivered event.
          ptr_next   = (idx_reg == lwidth'(width - 1)) ? '0
                                                       : idx_reg + lwidth'(1);
          state_next = CLEAR;
        end
      end

      CLEAR: begin
        // The clear pulse is visible during this cycle; the latch drops the
        // bit at the closing edge, before IDLE samples pend again.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        v_next     = 1'b0;
      end
    endcase
  end

  assign o_v   = v_reg;
  assign o_idx = idx_reg;
  assign clr   = clr_reg;
  assign o_cnt = cnt_reg;

endmodule

// File: tb/tb_base_sr_event_arb.sv
// -----------------------------------------------------------------------------
// tb_base_sr_event_arb
//
// Two instances: the default 8-flag build, checked every cycle against an
// event-level model, and a 6-flag build with a 3-bit counter for index wrap
// and counter wrap. Each instance is fed by a sticky latch (set wins over rst)
// whose rst is the arbiter's clr.
// -----------------------------------------------------------------------------
module tb_base_sr_event_arb;

  localparam int W   = 8;
  localparam int LW  = 3;
  localparam int CW  = 16;
  localparam int WB  = 6;
  localparam int LWB = 3;
  localparam int CWB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic chk_en;

  logic [W-1:0]   set_a, pend_a, clr_a;
  logic           o_v_a, o_r_a;
  logic [LW-1:0]  o_idx_a;
  logic [CW-1:0]  o_cnt_a;

  logic [WB-1:0]  set_b, pend_b, clr_b;
  logic           o_v_b, o_r_b;
  logic [LWB-1:0] o_idx_b;
  logic [CWB-1:0] o_cnt_b;

  base_sr_event_arb #(.width(W), .lwidth(LW), .cwidth(CW)) dut_a (
    .clk(clk), .reset_n(reset_n), .pend(pend_a), .clr(clr_a),
    .o_v(o_v_a), .o_r(o_r_a), .o_idx(o_idx_a), .o_cnt(o_cnt_a)
  );

  base_sr_event_arb #(.width(WB), .lwidth(LWB), .cwidth(CWB)) dut_b (
    .clk(clk), .reset_n(reset_n), .pend(pend_b), .clr(clr_b),
    .o_v(o_v_b), .o_r(o_r_b), .o_idx(o_idx_b), .o_cnt(o_cnt_b)
  );

  // Sticky latches: set has priority over rst.
  always @(posedge clk) begin
    if (!chk_en) begin
      pend_a <= '0;
      pend_b <= '0;
    end else begin
      pend_a <= (pend_a & ~clr_a) | set_a;
      pend_b <= (pend_b & ~clr_b) | set_b;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bit_a(input int i);
    logic [W-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [WB-1:0] bit_b(input int i);
    logic [WB-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Nearest pending index going upward from ptr, modulo W; -1 when none.
  function automatic int rr_pick(input logic [W-1:0] p, input int ptr);
    int r;
    r = -1;
    for (int k = W - 1; k >= 0; k--) begin
      if (p[(ptr + k) % W]) r = (ptr + k) % W;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Event-level model of instance A: an offer is outstanding, or the cycle
  // after a delivery is spent clearing, or the arbiter looks at the flags.
  // ---------------------------------------------------------------------------
  logic         m_v, m_gap;
  int           m_idx, m_ptr, m_cnt;
  logic [W-1:0] m_clr;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_v   <= 1'b0;
      m_gap <= 1'b0;
      m_idx <= 0;
      m_ptr <= 0;
      m_cnt <= 0;
      m_clr <= '0;
    end else begin
      m_clr <= '0;
      if (m_v) begin
        if (o_r_a) begin
          m_v   <= 1'b0;
          m_clr <= bit_a(m_idx);
          m_cnt <= (m_cnt + 1) % (1 << CW);
          m_ptr <= (m_idx + 1) % W;
          m_gap <= 1'b1;
        end
      end else if (m_gap) begin
        m_gap <= 1'b0;
      end else if (pend_a != '0) begin
        m_idx <= rr_pick(pend_a, m_ptr);
        m_v   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_o_v", 64'(o_v_a), 64'(m_v));
      if (m_v) check("model_o_idx", 64'(o_idx_a), 64'(m_idx));
      check("model_clr", 64'(clr_a), 64'(m_clr));
      check("model_o_cnt", 64'(o_cnt_a), 64'(m_cnt));
    end
  end

  // Accepted indices (handshake seen mid-cycle, completes at next edge).
  int acc_a[$];
  int acc_b[$];
  int cnt_b[$];

  always @(negedge clk) begin
    if (chk_en && reset_n && o_v_a && o_r_a) acc_a.push_back(int'(o_idx_a));
    if (chk_en && reset_n && o_v_b && o_r_b) acc_b.push_back(int'(o_idx_b));
    if (chk_en && clr_b != '0)               cnt_b.push_back(int'(o_cnt_b));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int which, input int n, input int lim);
    int c;
    c = 0;
    while (((which == 0) ? acc_a.size() : acc_b.size()) < n && c < lim) begin
      @(negedge clk);
      c++;
    end
    check((which == 0) ? "wait_acc_a" : "wait_acc_b",
          64'(((which == 0) ? acc_a.size() : acc_b.size()) >= n), 64'(1));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    acc_a.delete();
    acc_b.delete();
    cnt_b.delete();
  endtask

  int exp_seq3[4] = '{1, 3, 6, 1};
  int exp_seq4[3] = '{6, 7, 0};
  int exp_seqb[8] = '{5, 0, 4, 5, 1, 2, 3, 4};
  int exp_cntb[8] = '{1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    int c;
    int npulse;
    reset_n = 1'b0;
    chk_en  = 1'b0;
    set_a   = '1;
    set_b   = '0;
    o_r_a   = 1'b1;
    o_r_b   = 1'b1;

    // 1. Reset with all flags set, then drain them in index order.
    step(1);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_o_v", 64'(o_v_a), 64'(0));
    check("rst_clr", 64'(clr_a), 64'(0));
    check("rst_o_cnt", 64'(o_cnt_a), 64'(0));
    check("rst_o_idx", 64'(o_idx_a), 64'(0));
    step(1);
    reset_n = 1'b1;
    set_a   = '0;
    @(negedge clk);
    check("rst2_o_v", 64'(o_v_a), 64'(0));
    check("rst2_clr", 64'(clr_a), 64'(0));
    check("rst2_o_cnt", 64'(o_cnt_a), 64'(0));
    @(negedge clk);
    check("rel_o_v", 64'(o_v_a), 64'(1));
    check("rel_o_idx", 64'(o_idx_a), 64'(0));
    wait_acc(0, 8, 60);
    for (int i = 0; i < 8 && i < acc_a.size(); i++) check("drain_seq", 64'(acc_a[i]), 64'(i));
    step(4);
    check("drain_cnt", 64'(o_cnt_a), 64'(8));

    // 2. Single event on bit 5.
    do_reset();
    set_a = bit_a(5);
    step(1);
    set_a = '0;
    @(negedge clk);
    check("single_v_early", 64'(o_v_a), 64'(0));
    @(negedge clk);
    check("single_o_v", 64'(o_v_a), 64'(1));
    check("single_o_idx", 64'(o_idx_a), 64'(5));
    @(negedge clk);
    check("single_clr", 64'(clr_a), 64'(8'h20));
    check("single_cnt", 64'(o_cnt_a), 64'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("single_no_repeat", 64'(o_v_a), 64'(0));
    end

    // 3. Round robin 1,3,6 with bit 1 re-armed after its clear.
    do_reset();
    set_a = bit_a(1) | bit_a(3) | bit_a(6);
    step(1);
    set_a = '0;
    c = 0;
    while (clr_a[1] !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("rr_clr1_seen", 64'(clr_a), 64'(8'h02));
    step(1);
    set_a = bit_a(1);
    step(1);
    set_a = '0;
    wait_acc(0, 4, 60);
    for (int i = 0; i < 4 && i < acc_a.size(); i++) check("rr_seq", 64'(acc_a[i]), 64'(exp_seq3[i]));

    // 4. Wrap: after 6 is delivered ptr sits at 7; bits 7 and 0 follow.
    do_reset();
    set_a = bit_a(6);
    step(1);
    set_a = '0;
    wait_acc(0, 1, 20);
    step(4);
    set_a = bit_a(0) | bit_a(7);
    step(1);
    set_a = '0;
    wait_acc(0, 3, 40);
    for (int i = 0; i < 3 && i < acc_a.size(); i++) check("wrap_seq", 64'(acc_a[i]), 64'(exp_seq4[i]));

    // 5. Backpressure with bits 2 and 4 pending.
    do_reset();
    o_r_a = 1'b0;
    set_a = bit_a(2) | bit_a(4);
    step(1);
    set_a = '0;
    step(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_o_v", 64'(o_v_a), 64'(1));
      check("bp_o_idx", 64'(o_idx_a), 64'(2));
      check("bp_clr", 64'(clr_a), 64'(0));
    end
    step(1);
    o_r_a  = 1'b1;
    npulse = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (clr_a != '0) begin
        npulse++;
        check("bp_pulse_bit", 64'(clr_a), 64'(8'h04));
      end
    end
    check("bp_pulse_count", 64'(npulse), 64'(1));
    wait_acc(0, 2, 30);
    if (acc_a.size() >= 2) check("bp_second", 64'(acc_a[1]), 64'(4));

    // 6. Reset during CLEAR of bit 3; bit 1 arrives during reset, 5 still set.
    do_reset();
    set_a = bit_a(3) | bit_a(5);
    step(1);
    set_a = '0;
    c = 0;
    while (clr_a == '0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("mid_clr_seen", 64'(clr_a), 64'(8'h08));
    reset_n = 1'b0;
    step(1);
    set_a = bit_a(1);
    @(negedge clk);
    check("mid_clr_zero", 64'(clr_a), 64'(0));
    check("mid_cnt_zero", 64'(o_cnt_a), 64'(0));
    check("mid_v_zero", 64'(o_v_a), 64'(0));
    step(1);
    set_a   = '0;
    reset_n = 1'b1;
    acc_a.delete();
    wait_acc(0, 2, 40);
    if (acc_a.size() >= 2) begin
      check("mid_first", 64'(acc_a[0]), 64'(1));
      check("mid_second", 64'(acc_a[1]), 64'(5));
    end
    step(4);
    check("mid_cnt_after", 64'(o_cnt_a), 64'(2));

    // 6-flag build: index wrap 5 -> 0 and 3-bit counter wrap.
    do_reset();
    set_b = bit_b(5);
    step(1);
    set_b = '0;
    wait_acc(1, 1, 20);
    step(4);
    set_b = bit_b(0) | bit_b(4);
    step(1);
    set_b = '0;
    wait_acc(1, 3, 30);
    step(4);
    set_b = bit_b(1) | bit_b(2) | bit_b(3) | bit_b(4) | bit_b(5);
    step(1);
    set_b = '0;
    wait_acc(1, 8, 60);
    step(4);
    for (int i = 0; i < 8 && i < acc_b.size(); i++) check("b_seq", 64'(acc_b[i]), 64'(exp_seqb[i]));
    check("b_cnt_len", 64'(cnt_b.size()), 64'(8));
    for (int i = 0; i < 8 && i < cnt_b.size(); i++) check("b_cnt", 64'(cnt_b[i]), 64'(exp_cntb[i]));
    check("b_cnt_final", 64'(o_cnt_b), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
